// File: rtl/qif_spike_decoder_if.sv
// Result port of the QIF spike decoder: spike/enable inputs plus the
// valid/ready result channel carrying rate, isi and the overrun flag.
interface qif_spike_decoder_if #(
   parameter int COUNT_W = 8,
   parameter int ISI_W   = 16
);
   logic               spike_in;
   logic               enable;
   logic               out_ready;
   logic               out_valid;
   logic [COUNT_W-1:0] rate;
   logic [ISI_W-1:0]   isi;
   logic               overrun;

   // Decoder side: consumes the spike line and drives the result channel.
   modport master (
      input  spike_in,
      input  enable,
      input  out_ready,
      output out_valid,
      output rate,
      output isi,
      output overrun
   );

   // Neuron/readout side: drives the spike line and accepts results.
   modport slave (
      output spike_in,
      output enable,
      output out_ready,
      input  out_valid,
      input  rate,
      input  isi,
      input  overrun
   );
endinterface

// File: rtl/qif_spike_decoder.sv
// QIF spike decoder: counts spike rising edges over a 2^WINDOW_LOG2-cycle
// window (rate) and tracks the most recent inter-spike interval (isi).
// Each completed window is presented on a valid/ready result port.
module qif_spike_decoder #(
   parameter int WINDOW_LOG2 = 8,
   parameter int COUNT_W     = 8,
   parameter int ISI_W       = 16
) (
   input  logic                clk,
   input  logic                rst,
   qif_spike_decoder_if.master bus
);

   typedef enum logic {
      IDLE,
      COUNT
   } state_e;

   localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
   localparam logic [COUNT_W-1:0]     SPK_MAX  = '1;
   localparam logic [ISI_W-1:0]       ISI_MAX  = '1;

   state_e                 state_q, state_d;
   logic                   spike_q, spike_d;
   logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
   logic [COUNT_W-1:0]     spk_cnt_q, spk_cnt_d;
   logic [ISI_W-1:0]       isi_cnt_q, isi_cnt_d;
   logic [ISI_W-1:0]       last_isi_q, last_isi_d;
   logic                   armed_q, armed_d;
   logic                   out_valid_q, out_valid_d;
   logic [COUNT_W-1:0]     rate_q, rate_d;
   logic [ISI_W-1:0]       isi_q, isi_d;
   logic                   overrun_q, overrun_d;

   logic                   spike_edge;
   logic [ISI_W-1:0]       isi_inc;
   logic [COUNT_W-1:0]     spk_next;
   logic                   window_close;
   logic                   transfer;

   assign spike_edge = bus.spike_in & ~spike_q;
   assign isi_inc    = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + ISI_W'(1);
   assign spk_next   = (spike_edge && spk_cnt_q != SPK_MAX) ? spk_cnt_q + COUNT_W'(1)
                                                            : spk_cnt_q;
   assign transfer   = out_valid_q & bus.out_ready;

   // Edge history and interval measurement; runs in every state.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      spike_d    = bus.spike_in;
      isi_cnt_d  = isi_inc;
      last_isi_d = last_isi_q;
      armed_d    = armed_q;
      if (spike_edge) begin
         // The first edge after reset only arms; later edges close an interval.
         if (armed_q) begin
            last_isi_d = isi_inc;
         end
         isi_cnt_d = '0;
         armed_d   = 1'b1;
      end
   end

   // Window FSM: IDLE waits for enable, COUNT accumulates edges per window.
   always_comb begin
      state_d      = state_q;
      win_cnt_d    = win_cnt_q;
      spk_cnt_d    = spk_cnt_q;
      window_close = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.enable) begin
               state_d   = COUNT;
               win_cnt_d = '0;
               spk_cnt_d = '0;
            end
         end
         COUNT: begin
            if (!bus.enable) begin
               // Partial window is dropped; the held result stays untouched.
               state_d   = IDLE;
               win_cnt_d = '0;
               spk_cnt_d = '0;
            end else begin
               win_cnt_d = win_cnt_q + WINDOW_LOG2'(1);
               if (win_cnt_q == WIN_LAST) begin
                  // Next window starts on the following cycle with no gap.
                  window_close = 1'b1;
                  spk_cnt_d    = '0;
               end else begin
                  spk_cnt_d = spk_next;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Result channel: load on window close, release on accepted transfer.
   always_comb begin
      out_valid_d = out_valid_q;
      rate_d      = rate_q;
      isi_d       = isi_q;
      overrun_d   = overrun_q;
      if (window_close) begin
         out_valid_d = 1'b1;
         rate_d      = spk_next;
         isi_d       = last_isi_d;
         if (out_valid_q && !bus.out_ready) begin
            overrun_d = 1'b1;
         end else if (transfer) begin
            overrun_d = 1'b0;
         end
      end else if (transfer) begin
         out_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= IDLE;
         spike_q     <= 1'b0;
         win_cnt_q   <= '0;
         spk_cnt_q   <= '0;
         isi_cnt_q   <= '0;
         last_isi_q  <= '0;
         armed_q     <= 1'b0;
         out_valid_q <= 1'b0;
         rate_q      <= '0;
         isi_q       <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         spike_q     <= spike_d;
         win_cnt_q   <= win_cnt_d;
         spk_cnt_q   <= spk_cnt_d;
         isi_cnt_q   <= isi_cnt_d;
         last_isi_q  <= last_isi_d;
         armed_q     <= armed_d;
         out_valid_q <= out_valid_d;
         rate_q      <= rate_d;
         isi_q       <= isi_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.rate      = rate_q;
   assign bus.isi       = isi_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Directed bench for qif_spike_decoder. dut_a uses a 16-cycle window for
// rate/ISI/handshake behaviour; dut_b uses a 1024-cycle window to reach
// rate saturation.
module tb_qif_spike_decoder;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] vhist;
   logic [15:0] ohist;
   logic [7:0]  rate_mid;

   qif_spike_decoder_if if_a ();
   qif_spike_decoder_if if_b ();

   qif_spike_decoder #(.WINDOW_LOG2(4), .COUNT_W(8), .ISI_W(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   qif_spike_decoder #(.WINDOW_LOG2(10), .COUNT_W(8), .ISI_W(16)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 16-cycle window on dut_a: per-cycle spike and ready, recording
   // out_valid / overrun after each edge and rate mid-window.
   task automatic run_window(input logic [15:0] spk, input logic [15:0] rdy);
      for (int k = 0; k < 16; k++) begin
         if_a.spike_in  = spk[k];
         if_a.out_ready = rdy[k];
         tick();
         vhist[k] = if_a.out_valid;
         ohist[k] = if_a.overrun;
         if (k == 7) rate_mid = if_a.rate;
      end
   endtask

   initial begin
      logic [15:0] abort_pat;
      if_a.spike_in = 1'b0; if_a.enable = 1'b0; if_a.out_ready = 1'b1;
      if_b.spike_in = 1'b0; if_b.enable = 1'b0; if_b.out_ready = 1'b1;
      rst = 1'b1;

      // Reset held two cycles while spike_in toggles.
      if_a.spike_in = 1'b1; tick();
      if_a.spike_in = 1'b0; tick();
      rst = 1'b0;
      check("reset_valid",   if_a.out_valid, 0);
      check("reset_rate",    if_a.rate,      0);
      check("reset_isi",     if_a.isi,       0);
      check("reset_overrun", if_a.overrun,   0);

      // Enable: one cycle IDLE->COUNT, then window cycle 0.
      if_a.enable = 1'b1;
      tick();

      // Regular train, pulses on cycles 0,4,8,12.
      run_window(16'h1111, 16'hFFFF);
      check("w1_vhist",    vhist,    16'h8000);
      check("w1_rate_mid", rate_mid, 0);
      check("w1_rate",     if_a.rate, 4);
      check("w1_isi",      if_a.isi,  4);
      run_window(16'h1111, 16'hFFFF);
      check("w2_vhist", vhist,     16'h8000);
      check("w2_rate",  if_a.rate, 4);
      check("w2_isi",   if_a.isi,  4);

      // Level high on cycles 2-11, fresh pulse on the closing cycle 15.
      run_window(16'h8FFC, 16'hFFFF);
      check("held_rate", if_a.rate, 2);
      check("held_isi",  if_a.isi,  13);

      // Backpressure: held result overwritten twice (3 then 5 spikes).
      run_window(16'h0222, 16'h0000);
      check("bp1_vhist",    vhist,     16'hFFFF);
      check("bp1_ohist",    ohist,     16'h8000);
      check("bp1_rate_mid", rate_mid,  2);
      check("bp1_rate",     if_a.rate, 3);
      check("bp1_isi",      if_a.isi,  4);
      run_window(16'h0155, 16'h0000);
      check("bp2_ohist",    ohist,     16'hFFFF);
      check("bp2_rate_mid", rate_mid,  3);
      check("bp2_rate",     if_a.rate, 5);
      check("bp2_isi",      if_a.isi,  2);
      check("bp2_overrun",  if_a.overrun, 1);

      // Ready raised: transfer on cycle 0 clears valid and overrun.
      run_window(16'h0101, 16'hFFFF);
      check("drain_vhist", vhist,     16'h8000);
      check("drain_ohist", ohist,     16'h0000);
      check("drain_rate",  if_a.rate, 2);
      check("drain_isi",   if_a.isi,  8);

      // Close coinciding with transfer: valid stays up, no overrun.
      run_window(16'h1248, 16'h8000);
      check("simul_vhist", vhist,        16'hFFFF);
      check("simul_ohist", ohist,        16'h0000);
      check("simul_rate",  if_a.rate,    4);
      check("simul_isi",   if_a.isi,     3);

      // Abort after 3 spikes: enable drops at window cycle 9.
      abort_pat = 16'h0049;
      if_a.out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if_a.spike_in = abort_pat[k];
         tick();
      end
      if_a.spike_in = 1'b0; if_a.enable = 1'b0; tick();
      check("abort_valid", if_a.out_valid, 0);
      check("abort_rate",  if_a.rate,      4);
      // A spike in IDLE must not reach the next window's count.
      if_a.spike_in = 1'b1; tick();
      if_a.spike_in = 1'b0; tick();
      tick();
      check("idle_valid", if_a.out_valid, 0);
      if_a.enable = 1'b1; tick();
      run_window(16'h0202, 16'hFFFF);
      check("reen_vhist", vhist,     16'h8000);
      check("reen_rate",  if_a.rate, 2);
      check("reen_isi",   if_a.isi,  8);

      // Reset mid-window: partial window discarded, ISI disarmed.
      if_a.spike_in = 1'b1; tick();
      if_a.spike_in = 1'b0; tick();
      if_a.spike_in = 1'b1; tick();
      if_a.spike_in = 1'b0; tick();
      tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      check("mrst_valid",   if_a.out_valid, 0);
      check("mrst_rate",    if_a.rate,      0);
      check("mrst_isi",     if_a.isi,       0);
      check("mrst_overrun", if_a.overrun,   0);
      tick();
      run_window(16'h0010, 16'hFFFF);
      check("single_vhist", vhist,     16'h8000);
      check("single_rate",  if_a.rate, 1);
      check("single_isi",   if_a.isi,  0);

      // ISI saturation: 70000 quiet cycles, then one pulse.
      for (int w = 0; w < 4375; w++) run_window(16'h0000, 16'hFFFF);
      check("quiet_rate", if_a.rate, 0);
      check("quiet_isi",  if_a.isi,  0);
      run_window(16'h0001, 16'hFFFF);
      check("isisat_rate", if_a.rate, 1);
      check("isisat_isi",  if_a.isi,  65535);

      // Rate saturation on the 1024-cycle window: 512 edges.
      if_a.enable = 1'b0;
      check("b_idle_valid", if_b.out_valid, 0);
      if_b.enable = 1'b1; tick();
      for (int k = 0; k < 1024; k++) begin
         if_b.spike_in = (k % 2 == 0);
         tick();
      end
      check("ratesat_valid", if_b.out_valid, 1);
      check("ratesat_rate",  if_b.rate,      255);
      check("ratesat_isi",   if_b.isi,       2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
